muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 40: maximum cycles in RUN before a watchdog abort.
REQ-002 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1: reset, synchronous, active-high.
REQ-004 Port id_valid  input  1: the decode stage presents a HI/LO-class instruction this cycle.
REQ-005 Port id_op  input  5: op code; 01100 MULT, 01101 MULTU, 01110 DIV, 01111 DIVU, 01001 MTHI, 01011 MTLO; any other value is a NOP.
REQ-006 Port id_rd_hilo  input  1: the decode stage instruction reads HI or LO (MFHI/MFLO).
REQ-007 Port unit_done  input  1: one-cycle completion pulse from the multi-cycle unit (its stall output).
REQ-008 Port unit_start  output  1: start strobe to the multi-cycle unit.
REQ-009 Port unit_op  output  5: op code to the multi-cycle unit.
REQ-010 Port busy  output  1: a mul/div operation is in flight.
REQ-011 Port pipe_stall  output  1: hold the decode stage this cycle.
REQ-012 Port err  output  1: sticky watchdog-timeout flag.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DRAIN.
REQ-014 The block SHALL define MD = id_valid AND id_op in {01100, 01101, 01110, 01111}.
REQ-015 The block SHALL define MT = id_valid AND id_op in {01001, 01011}.
REQ-016 IDLE, MD true: assert unit_start for exactly one cycle, latch id_op into op_q, clear cyc, and go to RUN next cycle.
REQ-017 IDLE, MT true: unit_start SHALL stay 0.
REQ-018 IDLE, MT true: unit_op SHALL equal id_op combinationally, so the unit writes HI/LO on the same edge.
REQ-019 IDLE, neither MD nor MT: unit_op SHALL be 00000 and unit_start SHALL be 0.
REQ-020 RUN: unit_op SHALL equal op_q for every cycle; the unit decodes op on every iteration.
REQ-021 RUN: cyc (6-bit) SHALL increment by 1 each cycle, saturating at 63.
REQ-022 RUN: on unit_done=1, go to DRAIN.
REQ-023 RUN: on cyc==TIMEOUT-1 without unit_done, set err, go to IDLE, and drive unit_op=00000.
REQ-024 DRAIN: lasts one cycle with unit_op=op_q, then goes to IDLE; this lets the unit return to its own idle state.
REQ-025 busy SHALL be 1 in RUN and DRAIN, and 0 otherwise.
REQ-026 pipe_stall SHALL be combinational: busy AND (MD OR MT OR (id_valid AND id_rd_hilo)).
REQ-027 While pipe_stall=1, no MD or MT SHALL be accepted.
REQ-028 Non-HI/LO instructions SHALL never stall.
REQ-029 MD arriving in the same cycle the FSM enters IDLE from DRAIN SHALL be accepted on that IDLE cycle.
REQ-030 unit_start and MT passthrough SHALL never be active in the same cycle.
REQ-031 Nominal latency SHALL be 35 cycles from the accept edge to the first cycle an MD/MFHI/MFLO is no longer stalled, given unit_done at RUN cycle 33.
REQ-032 err SHALL be cleared only by rst.
REQ-033 err SHALL NOT block new operations.
REQ-034 unit_done received in IDLE or DRAIN SHALL be ignored.

Reset
REQ-035 rst=1 SHALL force the following on the next edge, from any state including mid-RUN: state=IDLE, op_q=0, cyc=0, err=0.
REQ-036 While rst=1, outputs SHALL be unit_start=0, unit_op=00000, busy=0, pipe_stall=0.
REQ-037 The first cycle after rst deasserts SHALL accept MD normally.
REQ-038 Reset SHALL NOT emit any start or MT op to the unit.

Verification
REQ-039 MULT issue: id_op=01100, unit_done at RUN cycle 33 -> unit_start one cycle; busy for 34 cycles; unit_op=01100 throughout; busy=0 afterwards.
REQ-040 MFLO while busy: id_rd_hilo=1 at RUN cycle 5 -> pipe_stall=1 until DRAIN exits; pipe_stall=0 on the first IDLE cycle.
REQ-041 MTHI in IDLE: id_op=01001 -> unit_op=01001 in the same cycle; unit_start=0; busy stays 0.
REQ-042 Back-to-back: DIVU then DIV presented during RUN -> DIV stalled; DIV accepted on the first IDLE cycle; unit_start pulses exactly twice in total.
REQ-043 Watchdog: unit_done held 0, TIMEOUT=40 -> err=1 after 40 RUN cycles; state=IDLE; the next MULTU is accepted.
REQ-044 Reset mid-op: rst at RUN cycle 10 -> next cycle busy=0, err=0, unit_op=00000; a late unit_done is ignored.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// Issue/stall controller for a multi-cycle HI/LO multiply-divide unit.
// Starts MD ops, passes MT ops through, stalls HI/LO readers and aborts hung ops.
module muldiv_ctrl #(
    parameter int TIMEOUT = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_op,
    input  logic       id_rd_hilo,
    input  logic       unit_done,
    output logic       unit_start,
    output logic [4:0] unit_op,
    output logic       busy,
    output logic       pipe_stall,
    output logic       err
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [4:0] OP_NONE  = 5'b00000;
    localparam logic [5:0] CYC_LAST = 6'(TIMEOUT - 1);
    localparam logic [5:0] CYC_MAX  = 6'h3f;

    state_t     state;
    state_t     state_next;
    logic [4:0] op_q;
    logic [5:0] cyc;
    logic       md;
    logic       mt;
    logic       timeout;

    assign md = id_valid && (id_op inside {5'b01100, 5'b01101, 5'b01110, 5'b01111});
    assign mt = id_valid && (id_op inside {5'b01001, 5'b01011});

    always_comb begin
        // NOTE: every signal written here gets a default first so no path infers a latch.
        state_next = state;
        unit_start = 1'b0;
        unit_op    = OP_NONE;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (md) begin
                    unit_start = 1'b1;
                    unit_op    = id_op;
                    state_next = RUN;
                end else if (mt) begin
                    unit_op = id_op;
                end
            end
            RUN: begin
                unit_op = op_q;
                if (unit_done) begin
                    state_next = DRAIN;
                end else if (cyc == CYC_LAST) begin
                    // Abort cleanly: the unit sees a NOP and falls back to its own idle.
                    timeout    = 1'b1;
                    unit_op    = OP_NONE;
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                unit_op    = op_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (rst) begin
            unit_start = 1'b0;
            unit_op    = OP_NONE;
        end
    end

    assign busy       = !rst && (state != IDLE);
    assign pipe_stall = busy && (md || mt || (id_valid && id_rd_hilo));

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state <= IDLE;
            op_q  <= OP_NONE;
            cyc   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            if (unit_start) begin
                op_q <= id_op;
                cyc  <= '0;
            end else if (state == RUN && cyc != CYC_MAX) begin
                cyc <= cyc + 6'd1;
            end
            if (timeout) begin
                err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: vector tables for combinational decode,
// hand-written sequences for issue, stall, back-to-back, watchdog and reset.
module tb_muldiv_ctrl;
    localparam int TIMEOUT = 40;

    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_MULT  = 5'b01100;
    localparam logic [4:0] OP_MULTU = 5'b01101;
    localparam logic [4:0] OP_DIV   = 5'b01110;
    localparam logic [4:0] OP_DIVU  = 5'b01111;
    localparam logic [4:0] OP_MTHI  = 5'b01001;
    localparam logic [4:0] OP_MTLO  = 5'b01011;

    typedef struct {
        logic       v;
        logic [4:0] op;
        logic       rd;
        logic       start;
        logic [4:0] uop;
        logic       busy;
        logic       stall;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_op;
    logic       id_rd_hilo;
    logic       unit_done;
    logic       unit_start;
    logic [4:0] unit_op;
    logic       busy;
    logic       pipe_stall;
    logic       err;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_starts = 0;
    logic [4:0] sb_q[$];

    vec_t idle_tab[8];
    vec_t run_tab[4];

    muldiv_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .id_valid  (id_valid),
        .id_op     (id_op),
        .id_rd_hilo(id_rd_hilo),
        .unit_done (unit_done),
        .unit_start(unit_start),
        .unit_op   (unit_op),
        .busy      (busy),
        .pipe_stall(pipe_stall),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every start strobe must match the oldest expected op.
    always @(negedge clk) begin
        if (unit_start === 1'b1) begin
            n_starts++;
            if (sb_q.size() == 0) begin
                check("unexpected_start", 32'd1, 32'd0);
            end else begin
                check("start_op", {27'd0, unit_op}, {27'd0, sb_q.pop_front()});
            end
        end
    end

    // Inputs change 1 time unit after the edge; outputs are sampled 3 units later.
    task automatic drive(input logic r, input logic v, input logic [4:0] op,
                         input logic rd, input logic d);
        @(posedge clk);
        #1;
        rst        = r;
        id_valid   = v;
        id_op      = op;
        id_rd_hilo = rd;
        unit_done  = d;
        #3;
    endtask

    task automatic apply(input vec_t t, input string tag);
        drive(1'b0, t.v, t.op, t.rd, 1'b0);
        check({tag, "_start"}, {31'd0, unit_start}, {31'd0, t.start});
        check({tag, "_op"},    {27'd0, unit_op},    {27'd0, t.uop});
        check({tag, "_busy"},  {31'd0, busy},       {31'd0, t.busy});
        check({tag, "_stall"}, {31'd0, pipe_stall}, {31'd0, t.stall});
    endtask

    initial begin
        int busy_cnt;
        int op_bad;
        int start_bad;
        int stall_bad;
        int starts0;

        //                 v     op          rd    start uop      busy  stall
        idle_tab[0] = '{1'b0, OP_NOP,     1'b0, 1'b0, OP_NOP,  1'b0, 1'b0};
        idle_tab[1] = '{1'b1, OP_MTHI,    1'b0, 1'b0, OP_MTHI, 1'b0, 1'b0};
        idle_tab[2] = '{1'b1, OP_MTLO,    1'b0, 1'b0, OP_MTLO, 1'b0, 1'b0};
        idle_tab[3] = '{1'b0, OP_MTHI,    1'b0, 1'b0, OP_NOP,  1'b0, 1'b0};
        idle_tab[4] = '{1'b1, 5'b01000,   1'b0, 1'b0, OP_NOP,  1'b0, 1'b0};
        idle_tab[5] = '{1'b1, 5'b01010,   1'b0, 1'b0, OP_NOP,  1'b0, 1'b0};
        idle_tab[6] = '{1'b1, OP_NOP,     1'b1, 1'b0, OP_NOP,  1'b0, 1'b0};
        idle_tab[7] = '{1'b0, OP_MULT,    1'b1, 1'b0, OP_NOP,  1'b0, 1'b0};
        // Applied during the RUN phase of a MULT.
        run_tab[0]  = '{1'b1, OP_DIV,     1'b0, 1'b0, OP_MULT, 1'b1, 1'b1};
        run_tab[1]  = '{1'b1, OP_MTLO,    1'b0, 1'b0, OP_MULT, 1'b1, 1'b1};
        run_tab[2]  = '{1'b1, 5'b00011,   1'b0, 1'b0, OP_MULT, 1'b1, 1'b0};
        run_tab[3]  = '{1'b0, OP_MULT,    1'b1, 1'b0, OP_MULT, 1'b1, 1'b0};

        rst = 1'b1; id_valid = 1'b0; id_op = OP_NOP; id_rd_hilo = 1'b0; unit_done = 1'b0;

        // Reset with live stimulus: nothing may reach the unit.
        drive(1'b1, 1'b1, OP_MULT, 1'b1, 1'b1);
        check("rst_start", {31'd0, unit_start}, 32'd0);
        check("rst_op",    {27'd0, unit_op},    32'd0);
        check("rst_busy",  {31'd0, busy},       32'd0);
        check("rst_stall", {31'd0, pipe_stall}, 32'd0);
        drive(1'b1, 1'b1, OP_MTHI, 1'b0, 1'b0);
        check("rst_mt_op", {27'd0, unit_op},    32'd0);
        check("rst_err",   {31'd0, err},        32'd0);

        // MULT on the first cycle after reset, MFLO from RUN cycle 5, done at RUN cycle 33.
        sb_q.push_back(OP_MULT);
        drive(1'b0, 1'b1, OP_MULT, 1'b0, 1'b0);
        check("mult_start", {31'd0, unit_start}, 32'd1);
        check("mult_busy0", {31'd0, busy},       32'd0);
        busy_cnt = 0; op_bad = 0; start_bad = 0; stall_bad = 0;
        for (int k = 1; k <= 35; k++) begin
            if (k <= 4) begin
                apply(run_tab[k-1], "run_tab");
            end else begin
                drive(1'b0, 1'b1, OP_NOP, 1'b1, (k == 33));
                if (k <= 34 && pipe_stall !== 1'b1) stall_bad++;
            end
            if (busy === 1'b1) busy_cnt++;
            if (k <= 34 && unit_op !== OP_MULT) op_bad++;
            if (unit_start !== 1'b0) start_bad++;
        end
        check("mult_busy_cycles", busy_cnt,  34);
        check("mult_op_held",     op_bad,    0);
        check("mult_no_restart",  start_bad, 0);
        check("mflo_stalled",     stall_bad, 0);
        check("mflo_released",    {31'd0, pipe_stall}, 32'd0);
        check("mult_idle_busy",   {31'd0, busy},       32'd0);
        check("mult_idle_op",     {27'd0, unit_op},    32'd0);

        foreach (idle_tab[i]) apply(idle_tab[i], "idle_tab");

        // unit_done while idle must not start anything.
        drive(1'b0, 1'b0, OP_NOP, 1'b0, 1'b1);
        drive(1'b0, 1'b0, OP_NOP, 1'b0, 1'b0);
        check("idle_done_ignored", {31'd0, busy}, 32'd0);

        // DIVU then DIV held during RUN: DIV waits and is taken on the first IDLE cycle.
        starts0 = n_starts;
        sb_q.push_back(OP_DIVU);
        drive(1'b0, 1'b1, OP_DIVU, 1'b0, 1'b0);
        check("divu_start", {31'd0, unit_start}, 32'd1);
        stall_bad = 0; op_bad = 0;
        for (int k = 1; k <= 11; k++) begin
            drive(1'b0, (k >= 3), (k >= 3) ? OP_DIV : OP_NOP, 1'b0, (k == 10));
            if (k >= 3 && pipe_stall !== 1'b1) stall_bad++;
            if (unit_op !== OP_DIVU) op_bad++;
        end
        check("div_stalled",  stall_bad, 0);
        check("divu_op_held", op_bad,    0);
        sb_q.push_back(OP_DIV);
        drive(1'b0, 1'b1, OP_DIV, 1'b0, 1'b0);
        check("div_start", {31'd0, unit_start}, 32'd1);
        check("div_stall", {31'd0, pipe_stall}, 32'd0);
        for (int k = 1; k <= 6; k++) drive(1'b0, 1'b0, OP_NOP, 1'b0, (k == 5));
        check("div_drain_op",   {27'd0, unit_op}, {27'd0, OP_DIV});
        check("div_drain_busy", {31'd0, busy},    32'd1);
        drive(1'b0, 1'b0, OP_NOP, 1'b0, 1'b1);
        check("div_idle_busy", {31'd0, busy}, 32'd0);
        check("b2b_start_count", n_starts - starts0, 2);

        // Watchdog: no completion, abort on RUN cycle 40.
        sb_q.push_back(OP_DIV);
        drive(1'b0, 1'b1, OP_DIV, 1'b0, 1'b0);
        op_bad = 0;
        for (int k = 1; k <= 40; k++) begin
            drive(1'b0, 1'b0, OP_NOP, 1'b0, 1'b0);
            if (k < 40 && unit_op !== OP_DIV) op_bad++;
        end
        check("wd_op_held",   op_bad, 0);
        check("wd_abort_op",  {27'd0, unit_op}, 32'd0);
        check("wd_abort_busy", {31'd0, busy},   32'd1);
        check("wd_err_before", {31'd0, err},    32'd0);
        sb_q.push_back(OP_MULTU);
        drive(1'b0, 1'b1, OP_MULTU, 1'b0, 1'b0);
        check("wd_err_set",    {31'd0, err},        32'd1);
        check("wd_idle_busy",  {31'd0, busy},       32'd0);
        check("multu_start",   {31'd0, unit_start}, 32'd1);
        check("multu_op",      {27'd0, unit_op},    {27'd0, OP_MULTU});

        // Reset at RUN cycle 10 of the MULTU, then a late completion pulse.
        for (int k = 1; k <= 9; k++) drive(1'b0, 1'b0, OP_NOP, 1'b0, 1'b0);
        check("err_sticky", {31'd0, err}, 32'd1);
        drive(1'b1, 1'b1, OP_MULT, 1'b1, 1'b0);
        check("midrst_start", {31'd0, unit_start}, 32'd0);
        check("midrst_op",    {27'd0, unit_op},    32'd0);
        check("midrst_busy",  {31'd0, busy},       32'd0);
        check("midrst_stall", {31'd0, pipe_stall}, 32'd0);
        drive(1'b0, 1'b0, OP_NOP, 1'b0, 1'b1);
        check("postrst_busy", {31'd0, busy},    32'd0);
        check("postrst_err",  {31'd0, err},     32'd0);
        check("postrst_op",   {27'd0, unit_op}, 32'd0);
        drive(1'b0, 1'b0, OP_NOP, 1'b0, 1'b0);
        check("late_done_ignored", {31'd0, busy}, 32'd0);

        @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
